id_issue_ctrl: RTL and testbench

- Decode-stage issue controller for the in-order LoongArch pipeline; sits between IF→ID and ID→EX.
- Owns the ID stage valid bit and the allowin/valid handshake.
- Keeps a per-register scoreboard of in-flight writes and stalls any instruction whose source registers are pending (RAW), or whose destination counter would overflow.
- Takes decoded register-use info for the instruction currently held in ID from the decode signal producer.

---
 rtl/id_issue_ctrl_pkg.sv | 33 +++
 rtl/id_scoreboard.sv | 83 ++++++++
 rtl/id_issue_ctrl.sv | 116 +++++++++++
 tb/tb_id_issue_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/id_issue_ctrl_pkg.sv
// id_issue_ctrl_pkg: shared widths and the ID->issue-control decode bus layout.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

package id_issue_ctrl_pkg;

  localparam int REG_NUM_DEF = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int SB_CNT_W    = 2;
  localparam int STALL_W_DEF = 32;

  typedef struct packed {
    logic                  rj_re;
    logic                  rk_re;
    logic                  rd_re;
    logic [REG_ADDR_W-1:0] rj;
    logic [REG_ADDR_W-1:0] rk;
    logic [REG_ADDR_W-1:0] rd;
    logic                  dest_we;
    logic [REG_ADDR_W-1:0] dest;
  } id_to_ic_bus_t;

  localparam int ID_TO_IC_BUS_W = $bits(id_to_ic_bus_t);

  // A source only blocks issue when it is read, is not r0 and has a write in flight.
  function automatic logic src_blocked(input logic re, input logic addr_nz, input logic pend);
    return re && addr_nz && pend;
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_scoreboard.sv
// id_scoreboard: per-GPR pending-write counters with three pending reads and one full check.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

module id_scoreboard
  import id_issue_ctrl_pkg::*;
#(
  parameter int REG_NUM = REG_NUM_DEF,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int CNT_W   = SB_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc_i,
  input  logic [ADDR_W-1:0]     inc_addr_i,
  input  logic                  dec_i,
  input  logic [ADDR_W-1:0]     dec_addr_i,
  input  logic [2:0][ADDR_W-1:0] rd_addr_i,
  output logic [2:0]            pend_o,
  input  logic [ADDR_W-1:0]     full_addr_i,
  output logic                  full_o
);

  logic [CNT_W-1:0]   cnt_q [REG_NUM];
  logic [CNT_W-1:0]   cnt_d [REG_NUM];
  logic [REG_NUM-1:0] inc_hit;
  logic [REG_NUM-1:0] dec_hit;
  logic               dec_underflow;

  always_comb begin
    inc_hit = '0;
    dec_hit = '0;
    for (int i = 1; i < REG_NUM; i++) begin
      inc_hit[i] = inc_i && (inc_addr_i == ADDR_W'(i));
      dec_hit[i] = dec_i && (dec_addr_i == ADDR_W'(i));
    end
  end

  // r0 is never tracked; a coincident inc and dec on one register cancel out.
  always_comb begin
    for (int i = 0; i < REG_NUM; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    cnt_d[0] = '0;
    for (int i = 1; i < REG_NUM; i++) begin
      if (inc_hit[i] && !dec_hit[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec_hit[i] && !inc_hit[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REG_NUM; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      pend_o[k] = (cnt_q[rd_addr_i[k]] != '0);
    end
  end

  assign full_o = (cnt_q[full_addr_i] == '1);

  assign dec_underflow = dec_i && (dec_addr_i != '0) &&
                         !(inc_i && (inc_addr_i == dec_addr_i)) &&
                         (cnt_q[dec_addr_i] == '0);

  a_no_dec_underflow: assert property (@(posedge clk) disable iff (rst) !dec_underflow);

endmodule

`default_nettype wire

// File: rtl/id_issue_ctrl.sv
// id_issue_ctrl: ID-stage valid/allowin handshake, RAW/overflow interlock and stall counter.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

module id_issue_ctrl
  import id_issue_ctrl_pkg::*;
#(
  parameter int REG_NUM = REG_NUM_DEF,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int CNT_W   = SB_CNT_W,
  parameter int STALL_W = STALL_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               if_to_id_valid_i,
  output logic               id_allowin_o,
  input  logic               ex_allowin_i,
  output logic               id_to_ex_valid_o,
  input  logic               rj_re_i,
  input  logic               rk_re_i,
  input  logic               rd_re_i,
  input  logic [ADDR_W-1:0]  rj_i,
  input  logic [ADDR_W-1:0]  rk_i,
  input  logic [ADDR_W-1:0]  rd_i,
  input  logic               dest_we_i,
  input  logic [ADDR_W-1:0]  dest_i,
  input  logic               wb_retire_i,
  input  logic               wb_we_i,
  input  logic [ADDR_W-1:0]  wb_dest_i,
  output logic               id_valid_o,
  output logic               hazard_o,
  output logic [STALL_W-1:0] stall_cnt_o
);

  logic                   id_valid_q;
  logic                   id_valid_d;
  logic [STALL_W-1:0]     stall_cnt_q;
  logic [STALL_W-1:0]     stall_cnt_d;
  logic [2:0][ADDR_W-1:0] src_addr;
  logic [2:0]             src_pend;
  logic                   dest_full;
  logic                   raw_hazard;
  logic                   ovf_hazard;
  logic                   ready_go;
  logic                   issue;
  logic                   sb_inc;
  logic                   sb_dec;

  assign src_addr = {rd_i, rk_i, rj_i};

  id_scoreboard #(
    .REG_NUM (REG_NUM),
    .ADDR_W  (ADDR_W),
    .CNT_W   (CNT_W)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .inc_i       (sb_inc),
    .inc_addr_i  (dest_i),
    .dec_i       (sb_dec),
    .dec_addr_i  (wb_dest_i),
    .rd_addr_i   (src_addr),
    .pend_o      (src_pend),
    .full_addr_i (dest_i),
    .full_o      (dest_full)
  );

  assign raw_hazard = src_blocked(rj_re_i, rj_i != '0, src_pend[0]) ||
                      src_blocked(rk_re_i, rk_i != '0, src_pend[1]) ||
                      src_blocked(rd_re_i, rd_i != '0, src_pend[2]);
  assign ovf_hazard = dest_we_i && (dest_i != '0) && dest_full;

  assign hazard_o         = id_valid_q && (raw_hazard || ovf_hazard);
  assign ready_go         = !hazard_o;
  assign id_allowin_o     = !id_valid_q || (ready_go && ex_allowin_i);
  assign id_to_ex_valid_o = id_valid_q && ready_go && !flush_i;
  assign issue            = id_to_ex_valid_o && ex_allowin_i;

  assign sb_inc = issue && dest_we_i && (dest_i != '0);
  assign sb_dec = wb_retire_i && wb_we_i && (wb_dest_i != '0);

  always_comb begin
    id_valid_d = id_valid_q;
    if (flush_i) begin
      id_valid_d = 1'b0;
    end else if (id_allowin_o) begin
      id_valid_d = if_to_id_valid_i;
    end
  end

  // Counts interlock cycles only; backpressure from EX is not a stall here.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (id_valid_q && !id_to_ex_valid_o && !flush_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      id_valid_q  <= id_valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign id_valid_o  = id_valid_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_id_issue_ctrl.sv
// tb_id_issue_ctrl: directed scenario bench for id_issue_ctrl.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_id_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        if_to_id_valid_i;
  logic        id_allowin_o;
  logic        ex_allowin_i;
  logic        id_to_ex_valid_o;
  logic        rj_re_i, rk_re_i, rd_re_i;
  logic [4:0]  rj_i, rk_i, rd_i;
  logic        dest_we_i;
  logic [4:0]  dest_i;
  logic        wb_retire_i;
  logic        wb_we_i;
  logic [4:0]  wb_dest_i;
  logic        id_valid_o;
  logic        hazard_o;
  logic [31:0] stall_cnt_o;

  int vecs = 0;
  int errs = 0;

  id_issue_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .flush_i          (flush_i),
    .if_to_id_valid_i (if_to_id_valid_i),
    .id_allowin_o     (id_allowin_o),
    .ex_allowin_i     (ex_allowin_i),
    .id_to_ex_valid_o (id_to_ex_valid_o),
    .rj_re_i          (rj_re_i),
    .rk_re_i          (rk_re_i),
    .rd_re_i          (rd_re_i),
    .rj_i             (rj_i),
    .rk_i             (rk_i),
    .rd_i             (rd_i),
    .dest_we_i        (dest_we_i),
    .dest_i           (dest_i),
    .wb_retire_i      (wb_retire_i),
    .wb_we_i          (wb_we_i),
    .wb_dest_i        (wb_dest_i),
    .id_valid_o       (id_valid_o),
    .hazard_o         (hazard_o),
    .stall_cnt_o      (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush_i = 0; if_to_id_valid_i = 0; ex_allowin_i = 1;
    rj_re_i = 0; rk_re_i = 0; rd_re_i = 0; rj_i = 0; rk_i = 0; rd_i = 0;
    dest_we_i = 0; dest_i = 0; wb_retire_i = 0; wb_we_i = 0; wb_dest_i = 0;
  endtask

  task automatic set_instr(input logic rjre, input logic [4:0] rj, input logic rkre,
                           input logic [4:0] rk, input logic rdre, input logic [4:0] rd,
                           input logic we, input logic [4:0] dest);
    rj_re_i = rjre; rj_i = rj; rk_re_i = rkre; rk_i = rk;
    rd_re_i = rdre; rd_i = rd; dest_we_i = we; dest_i = dest;
  endtask

  task automatic retire(input logic on, input logic [4:0] dest);
    wb_retire_i = on; wb_we_i = on; wb_dest_i = dest;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    #2;
    vecs++; if (id_valid_o !== 1'b0) begin errs++; $display("FAIL rst_valid got=%b exp=0", id_valid_o); end
    vecs++; if (id_allowin_o !== 1'b1) begin errs++; $display("FAIL rst_allowin got=%b exp=1", id_allowin_o); end
    vecs++; if (id_to_ex_valid_o !== 1'b0) begin errs++; $display("FAIL rst_toex got=%b exp=0", id_to_ex_valid_o); end
    vecs++; if (hazard_o !== 1'b0) begin errs++; $display("FAIL rst_hazard got=%b exp=0", hazard_o); end
    vecs++; if (stall_cnt_o !== 32'd0) begin errs++; $display("FAIL rst_stall got=%0d exp=0", stall_cnt_o); end
    tick();
    rst = 0;
  endtask

  task automatic test_raw();
    do_reset();
    if_to_id_valid_i = 1; tick();
    set_instr(0, 0, 0, 0, 0, 0, 1, 5'd4); #1;
    vecs++; if (id_to_ex_valid_o !== 1'b1) begin errs++; $display("FAIL raw_issue1 got=%b exp=1", id_to_ex_valid_o); end
    tick();
    set_instr(1, 5'd4, 0, 0, 0, 0, 1, 5'd5); if_to_id_valid_i = 0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) retire(1, 5'd4);
      #1;
      vecs++; if (hazard_o !== 1'b1 || id_to_ex_valid_o !== 1'b0)
        begin errs++; $display("FAIL raw_stall_c%0d hazard=%b toex=%b exp 1/0", c, hazard_o, id_to_ex_valid_o); end
      tick();
      retire(0, 0);
    end
    #1;
    vecs++; if (hazard_o !== 1'b0 || id_to_ex_valid_o !== 1'b1)
      begin errs++; $display("FAIL raw_release hazard=%b toex=%b exp 0/1", hazard_o, id_to_ex_valid_o); end
    vecs++; if (stall_cnt_o !== 32'd3) begin errs++; $display("FAIL raw_stallcnt got=%0d exp=3", stall_cnt_o); end
    tick();
    vecs++; if (id_valid_o !== 1'b0) begin errs++; $display("FAIL raw_drain got=%b exp=0", id_valid_o); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    if_to_id_valid_i = 1; tick();
    for (int k = 0; k < 2; k++) begin
      set_instr(0, 0, 0, 0, 0, 0, 1, 5'd5); tick();
    end
    set_instr(1, 5'd5, 0, 0, 0, 0, 0, 0); if_to_id_valid_i = 0; #1;
    vecs++; if (hazard_o !== 1'b1) begin errs++; $display("FAIL mid_hazard got=%b exp=1", hazard_o); end
    tick(); tick();
    rst = 1; #1;
    vecs++; if (id_valid_o !== 1'b0 || id_allowin_o !== 1'b1)
      begin errs++; $display("FAIL mid_rst valid=%b allowin=%b exp 0/1", id_valid_o, id_allowin_o); end
    vecs++; if (stall_cnt_o !== 32'd0) begin errs++; $display("FAIL mid_rst_stall got=%0d exp=0", stall_cnt_o); end
    tick();
    rst = 0; if_to_id_valid_i = 1; tick();
    if_to_id_valid_i = 0; #1;
    vecs++; if (hazard_o !== 1'b0 || id_to_ex_valid_o !== 1'b1)
      begin errs++; $display("FAIL mid_cnt_clear hazard=%b toex=%b exp 0/1", hazard_o, id_to_ex_valid_o); end
    tick();
  endtask

  task automatic test_r0();
    do_reset();
    if_to_id_valid_i = 1; tick();
    set_instr(0, 0, 0, 0, 0, 0, 1, 5'd0); #1;
    vecs++; if (id_to_ex_valid_o !== 1'b1) begin errs++; $display("FAIL r0_issue got=%b exp=1", id_to_ex_valid_o); end
    tick();
    set_instr(1, 0, 1, 0, 1, 0, 1, 5'd0); if_to_id_valid_i = 0; #1;
    vecs++; if (hazard_o !== 1'b0 || id_to_ex_valid_o !== 1'b1)
      begin errs++; $display("FAIL r0_read hazard=%b toex=%b exp 0/1", hazard_o, id_to_ex_valid_o); end
    tick();
  endtask

  task automatic test_simul_incdec();
    do_reset();
    if_to_id_valid_i = 1; tick();
    set_instr(0, 0, 0, 0, 0, 0, 1, 5'd7); tick();
    set_instr(0, 0, 0, 0, 0, 0, 1, 5'd7); retire(1, 5'd7); #1;
    vecs++; if (id_to_ex_valid_o !== 1'b1) begin errs++; $display("FAIL sim_issue got=%b exp=1", id_to_ex_valid_o); end
    tick();
    retire(0, 0);
    set_instr(1, 5'd7, 0, 0, 0, 0, 0, 0); if_to_id_valid_i = 0; #1;
    vecs++; if (hazard_o !== 1'b1) begin errs++; $display("FAIL sim_pending got=%b exp=1", hazard_o); end
    tick();
    retire(1, 5'd7); tick();
    retire(0, 0); #1;
    vecs++; if (hazard_o !== 1'b0 || id_to_ex_valid_o !== 1'b1)
      begin errs++; $display("FAIL sim_release hazard=%b toex=%b exp 0/1", hazard_o, id_to_ex_valid_o); end
    tick();
  endtask

  task automatic test_overflow();
    do_reset();
    if_to_id_valid_i = 1; tick();
    for (int k = 0; k < 3; k++) begin
      set_instr(0, 0, 0, 0, 0, 0, 1, 5'd9); #1;
      vecs++; if (id_to_ex_valid_o !== 1'b1) begin errs++; $display("FAIL ovf_issue%0d got=%b exp=1", k, id_to_ex_valid_o); end
      tick();
    end
    if_to_id_valid_i = 0; #1;
    vecs++; if (hazard_o !== 1'b1 || id_to_ex_valid_o !== 1'b0)
      begin errs++; $display("FAIL ovf_full hazard=%b toex=%b exp 1/0", hazard_o, id_to_ex_valid_o); end
    tick();
    retire(1, 5'd9); #1;
    vecs++; if (hazard_o !== 1'b1) begin errs++; $display("FAIL ovf_hold got=%b exp=1", hazard_o); end
    tick();
    retire(0, 0); #1;
    vecs++; if (hazard_o !== 1'b0 || id_to_ex_valid_o !== 1'b1)
      begin errs++; $display("FAIL ovf_release hazard=%b toex=%b exp 0/1", hazard_o, id_to_ex_valid_o); end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    if_to_id_valid_i = 1; tick();
    set_instr(0, 0, 0, 0, 0, 0, 1, 5'd3); tick();
    set_instr(1, 5'd3, 0, 0, 0, 0, 0, 0); if_to_id_valid_i = 0; #1;
    vecs++; if (hazard_o !== 1'b1) begin errs++; $display("FAIL fl_stall got=%b exp=1", hazard_o); end
    tick();
    flush_i = 1; if_to_id_valid_i = 1; #1;
    vecs++; if (id_to_ex_valid_o !== 1'b0 || id_valid_o !== 1'b1)
      begin errs++; $display("FAIL fl_cycle toex=%b valid=%b exp 0/1", id_to_ex_valid_o, id_valid_o); end
    tick();
    flush_i = 0; #1;
    vecs++; if (id_valid_o !== 1'b0 || id_allowin_o !== 1'b1)
      begin errs++; $display("FAIL fl_killed valid=%b allowin=%b exp 0/1", id_valid_o, id_allowin_o); end
    vecs++; if (stall_cnt_o !== 32'd1) begin errs++; $display("FAIL fl_stallcnt got=%0d exp=1", stall_cnt_o); end
    tick();
    if_to_id_valid_i = 0; #1;
    vecs++; if (id_valid_o !== 1'b1 || hazard_o !== 1'b1)
      begin errs++; $display("FAIL fl_refill valid=%b hazard=%b exp 1/1", id_valid_o, hazard_o); end
    flush_i = 1; retire(1, 5'd3); tick();
    flush_i = 0; retire(0, 0); if_to_id_valid_i = 1; tick();
    if_to_id_valid_i = 0; #1;
    vecs++; if (hazard_o !== 1'b0 || id_to_ex_valid_o !== 1'b1)
      begin errs++; $display("FAIL fl_retire hazard=%b toex=%b exp 0/1", hazard_o, id_to_ex_valid_o); end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    if_to_id_valid_i = 1; tick();
    set_instr(0, 0, 0, 0, 0, 0, 1, 5'd6); ex_allowin_i = 0; #1;
    vecs++; if (id_to_ex_valid_o !== 1'b1 || id_allowin_o !== 1'b0)
      begin errs++; $display("FAIL bp_hold toex=%b allowin=%b exp 1/0", id_to_ex_valid_o, id_allowin_o); end
    tick();
    #1;
    vecs++; if (id_valid_o !== 1'b1 || stall_cnt_o !== 32'd0)
      begin errs++; $display("FAIL bp_state valid=%b stall=%0d exp 1/0", id_valid_o, stall_cnt_o); end
    ex_allowin_i = 1; tick();
    set_instr(1, 5'd6, 0, 0, 0, 0, 0, 0); if_to_id_valid_i = 0; #1;
    vecs++; if (hazard_o !== 1'b1) begin errs++; $display("FAIL bp_single_inc got=%b exp=1", hazard_o); end
    retire(1, 5'd6); tick();
    retire(0, 0); #1;
    vecs++; if (hazard_o !== 1'b0) begin errs++; $display("FAIL bp_release got=%b exp=0", hazard_o); end
    tick();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_reset_midrun();
    test_r0();
    test_simul_incdec();
    test_overflow();
    test_flush();
    test_backpressure();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

`default_nettype wire
